trdb_pkt_scheduler: RTL

Packet scheduler for the trace encoder. It collects packet-generation requests from the instruction-qualification front end: trace start, trap, context change and uninferable-jump address. It also generates periodic resynchronisation requests. It issues one packet descriptor at a time, as a format/subformat pair, to the packet builder over a valid/ready handshake. It sits between the branch/event detection logic and the payload assembler, and is the only block that decides packet ordering.

---
 rtl/trdb_pkt_scheduler_pkg.sv | 42 ++++
 rtl/trdb_resync_counter.sv | 36 +++
 rtl/trdb_pkt_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/trdb_pkt_scheduler_pkg.sv
// rtl/trdb_pkt_scheduler_pkg.sv - shared trace-encoder types and scheduler constants
// Purpose: packet format/subformat encodings, scheduler FSM states,
//          request-index constants and a one-hot helper.
// Ports:   none (package).
package trdb_pkt_scheduler_pkg;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } trdb_subformat_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } trdb_sched_state_e;

  // Request indices double as priority order: lower index wins.
  localparam int REQ_START  = 0;
  localparam int REQ_TRAP   = 1;
  localparam int REQ_CTX    = 2;
  localparam int REQ_RESYNC = 3;
  localparam int REQ_ADDR   = 4;
  localparam int REQ_N      = 5;

  localparam int RESYNC_W_DEFAULT = 16;

  typedef logic [REQ_N-1:0] trdb_req_t;

  function automatic trdb_req_t req_bit(input int idx);
    return trdb_req_t'(1) << idx;
  endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// rtl/trdb_resync_counter.sv - periodic resynchronisation counter
// Purpose: counts cycles since the last full-address sync and pulses hit_o
//          on the cycle the count is about to reach max_i.
// Ports:   clk_i, rst_ni (async active-low), clr_i (restart count),
//          max_i (threshold, 0 disables), hit_o (one-cycle resync request).
module trdb_resync_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic         hit_o
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  // Saturates at max_i; a lowered threshold snaps the count down and still
  // produces one hit, so a change is honoured on the next compare.
  always_comb begin
    cnt_next = (cnt >= max_i) ? max_i : cnt + 1'b1;
    hit_o    = !clr_i && (max_i != '0) && (cnt != max_i) && (cnt_next == max_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/trdb_pkt_scheduler.sv
// rtl/trdb_pkt_scheduler.sv - trace packet scheduler (format/subformat issue)
// Purpose: merges pending and incoming packet requests, picks one by fixed
//          priority (start, trap, ctx, resync, addr) and presents it to the
//          packet builder over valid/ready. Optional periodic resync is
//          enabled by defining TRDB_RESYNC_EN.
// Ports:   clk_i, rst_ni (async active-low); start/trap/ctx/addr_req_i
//          request pulses; flush_i; resync_max_i; pkt_valid_o/pkt_ready_i
//          handshake; pkt_format_o, pkt_subformat_o descriptor;
//          dropped_o lost-request pulse.
module trdb_pkt_scheduler
  import trdb_pkt_scheduler_pkg::*;
#(
  parameter int RESYNC_W = RESYNC_W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_req_i,
  input  logic                trap_req_i,
  input  logic                ctx_req_i,
  input  logic                addr_req_i,
  input  logic                flush_i,
  input  logic [RESYNC_W-1:0] resync_max_i,
  output logic                pkt_valid_o,
  input  logic                pkt_ready_i,
  output trdb_format_e        pkt_format_o,
  output trdb_subformat_e     pkt_subformat_o,
  output logic                dropped_o
);

  trdb_sched_state_e state;
  trdb_req_t         pending;
  trdb_req_t         incoming;
  trdb_req_t         cand;
  trdb_req_t         clr_mask;
  trdb_req_t         consumed;
  trdb_req_t         pending_next;
  trdb_format_e      next_fmt;
  trdb_subformat_e   next_sub;
  logic              xfer;
  logic              load;
  logic              drop;
  logic              resync_hit;
  logic              resync_clr;

  // Any accepted full-address sync restarts the resync period.
  assign resync_clr = flush_i || (xfer && (pkt_format_o == F_SYNC) &&
                      ((pkt_subformat_o == SF_START) || (pkt_subformat_o == SF_TRAP)));

`ifdef TRDB_RESYNC_EN
  trdb_resync_counter #(.W(RESYNC_W)) u_resync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (resync_clr),
    .max_i  (resync_max_i),
    .hit_o  (resync_hit)
  );
`else
  logic unused_resync;
  assign unused_resync = ^{resync_max_i, resync_clr};
  assign resync_hit    = 1'b0;
`endif

  always_comb begin
    incoming = '0;
    if (!flush_i) begin
      incoming[REQ_START]  = start_req_i;
      incoming[REQ_TRAP]   = trap_req_i;
      incoming[REQ_CTX]    = ctx_req_i;
      incoming[REQ_RESYNC] = resync_hit;
      incoming[REQ_ADDR]   = addr_req_i;
    end
    cand = flush_i ? '0 : (pending | incoming);
    xfer = pkt_valid_o && pkt_ready_i;
    load = ((state == IDLE) || xfer) && (|cand);

    // Winner selection; the mask also drops requests the winner subsumes.
    clr_mask = '0;
    next_fmt = F_OPT_EXT;
    next_sub = SF_START;
    if (cand[REQ_START]) begin
      clr_mask = req_bit(REQ_START) | req_bit(REQ_RESYNC) | req_bit(REQ_ADDR);
      next_fmt = F_SYNC;
      next_sub = SF_START;
    end else if (cand[REQ_TRAP]) begin
      clr_mask = req_bit(REQ_TRAP) | req_bit(REQ_ADDR);
      next_fmt = F_SYNC;
      next_sub = SF_TRAP;
    end else if (cand[REQ_CTX]) begin
      clr_mask = req_bit(REQ_CTX);
      next_fmt = F_SYNC;
      next_sub = SF_CONTEXT;
    end else if (cand[REQ_RESYNC]) begin
      clr_mask = req_bit(REQ_START) | req_bit(REQ_RESYNC) | req_bit(REQ_ADDR);
      next_fmt = F_SYNC;
      next_sub = SF_START;
    end else if (cand[REQ_ADDR]) begin
      clr_mask = req_bit(REQ_ADDR);
      next_fmt = F_ADDR_ONLY;
      next_sub = SF_START;
    end

    consumed     = load ? clr_mask : '0;
    pending_next = cand & ~consumed;
    drop         = |(incoming & pending & ~consumed);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      pending         <= '0;
      pkt_valid_o     <= 1'b0;
      pkt_format_o    <= F_OPT_EXT;
      pkt_subformat_o <= SF_START;
      dropped_o       <= 1'b0;
    end else begin
      pending   <= pending_next;
      dropped_o <= drop;
      if (load) begin
        state           <= PRESENT;
        pkt_valid_o     <= 1'b1;
        pkt_format_o    <= next_fmt;
        pkt_subformat_o <= next_sub;
      end else if (xfer) begin
        state       <= IDLE;
        pkt_valid_o <= 1'b0;
      end
    end
  end

endmodule
